// File: rtl/valu_operand_feeder.sv
// Per-lane VALU operand feeder: fetches up to two operand streams from the VRF
// and pushes them, in address order, into the ALU operand FIFOs via small skid buffers.
module valu_operand_feeder #(
  parameter int LaneId        = 0,
  parameter int SkidDepth     = 2,
  parameter int VrfAddrW      = 5,
  parameter int VrfDataW      = 64,
  parameter int VlenW         = 16,
  parameter int InsnIdW       = 4,
  parameter int VrfWordWidthB = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [1:0][VrfAddrW-1:0]      req_vs_addr_i,
  input  logic [1:0]                    req_use_vs_i,
  input  logic [VlenW-1:0]              req_vlB_i,
  input  logic [InsnIdW-1:0]            req_insn_id_i,
  output logic [1:0]                    vrf_rd_req_o,
  output logic [1:0][VrfAddrW-1:0]      vrf_rd_addr_o,
  input  logic [1:0]                    vrf_rd_gnt_i,
  input  logic [1:0][VrfDataW-1:0]      vrf_rd_data_i,
  output logic [1:0]                    op_valid_o,
  input  logic [1:0]                    op_ready_i,
  output logic [1:0][VrfDataW-1:0]      alu_op_o,
  output logic                          feed_done_o,
  output logic [InsnIdW-1:0]            feed_done_id_o
);

  localparam int OccW = $clog2(SkidDepth + 1);
  localparam int PtrW = $clog2(SkidDepth);

  if (SkidDepth < 2 || LaneId < 0) begin : g_bad_param
    $error("valu_operand_feeder: SkidDepth must be >= 2 and LaneId >= 0");
  end

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e               r_state, w_state_nxt;
  logic                 w_accept;
  logic                 w_all_done;

  logic [VlenW-1:0]     r_words;
  logic [1:0]           r_use;
  logic [VrfAddrW-1:0]  r_base [2];
  logic [InsnIdW-1:0]   r_id;
  logic [VlenW-1:0]     w_words;

  logic [VlenW-1:0]     r_issue_cnt   [2];
  logic [VlenW-1:0]     r_deliver_cnt [2];
  logic [1:0]           r_inflight;
  logic [OccW-1:0]      r_occ    [2];
  logic [PtrW-1:0]      r_rd_ptr [2];
  logic [PtrW-1:0]      r_wr_ptr [2];
  logic [VrfDataW-1:0]  r_skid   [2][SkidDepth];

  logic [1:0]           w_fire;
  logic [1:0]           w_skid_ne;
  logic [1:0]           w_op_done;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(SkidDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Partial final word still costs one full VRF read.
  assign w_words = req_vlB_i / VlenW'(VrfWordWidthB)
                 + VlenW'(req_vlB_i % VlenW'(VrfWordWidthB) != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    req_ready_o = 1'b0;
    feed_done_o = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (w_all_done) begin
          feed_done_o = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Returning read data bypasses an empty skid so a granted word can push the next cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_skid_ne[i]     = (r_occ[i] != '0);
      vrf_rd_req_o[i]  = (r_state == ACTIVE) && r_use[i] && (r_issue_cnt[i] < r_words) &&
                         (({1'b0, r_occ[i]} + (OccW+1)'(r_inflight[i])) < (OccW+1)'(SkidDepth));
      vrf_rd_addr_o[i] = r_base[i] + VrfAddrW'(r_issue_cnt[i]);
      w_fire[i]        = vrf_rd_req_o[i] & vrf_rd_gnt_i[i];
      op_valid_o[i]    = (w_skid_ne[i] | r_inflight[i]) & op_ready_i[i];
      alu_op_o[i]      = w_skid_ne[i] ? r_skid[i][r_rd_ptr[i]] : vrf_rd_data_i[i];
      w_op_done[i]     = !r_use[i] || (r_deliver_cnt[i] == r_words);
    end
    w_all_done = &w_op_done;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_inflight <= '0;
      for (int i = 0; i < 2; i++) begin
        r_issue_cnt[i]   <= '0;
        r_deliver_cnt[i] <= '0;
        r_occ[i]         <= '0;
        r_rd_ptr[i]      <= '0;
        r_wr_ptr[i]      <= '0;
      end
    end else begin
      r_inflight <= w_fire;
      for (int i = 0; i < 2; i++) begin
        if (w_accept) begin
          r_issue_cnt[i]   <= '0;
          r_deliver_cnt[i] <= '0;
        end else begin
          if (w_fire[i])     r_issue_cnt[i]   <= r_issue_cnt[i] + 1'b1;
          if (op_valid_o[i]) r_deliver_cnt[i] <= r_deliver_cnt[i] + 1'b1;
        end
        if (op_valid_o[i])  r_rd_ptr[i] <= ptr_inc(r_rd_ptr[i]);
        if (r_inflight[i])  r_wr_ptr[i] <= ptr_inc(r_wr_ptr[i]);
        r_occ[i] <= r_occ[i] + OccW'(r_inflight[i]) - OccW'(op_valid_o[i]);
      end
    end
  end

  // NOTE: skid storage and job fields carry no reset; occupancy and state gate every use.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_words <= w_words;
      r_use   <= req_use_vs_i;
      r_id    <= req_insn_id_i;
      for (int i = 0; i < 2; i++) r_base[i] <= req_vs_addr_i[i];
    end
    for (int i = 0; i < 2; i++) begin
      if (r_inflight[i]) r_skid[i][r_wr_ptr[i]] <= vrf_rd_data_i[i];
    end
  end

  assign feed_done_id_o = r_id;

endmodule

// File: tb/tb_valu_operand_feeder.sv
// Directed bench for valu_operand_feeder: table of jobs with a VRF model, a push monitor,
// and hand sequences for reset during an in-flight read.
module tb_valu_operand_feeder;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [1:0][4:0]  req_vs_addr_i;
  logic [1:0]       req_use_vs_i;
  logic [15:0]      req_vlB_i;
  logic [3:0]       req_insn_id_i;
  logic [1:0]       vrf_rd_req_o;
  logic [1:0][4:0]  vrf_rd_addr_o;
  logic [1:0]       vrf_rd_gnt_i;
  logic [1:0][63:0] vrf_rd_data_i;
  logic [1:0]       op_valid_o;
  logic [1:0]       op_ready_i;
  logic [1:0][63:0] alu_op_o;
  logic             feed_done_o;
  logic [3:0]       feed_done_id_o;

  valu_operand_feeder dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_vs_addr_i(req_vs_addr_i), .req_use_vs_i(req_use_vs_i),
    .req_vlB_i(req_vlB_i), .req_insn_id_i(req_insn_id_i),
    .vrf_rd_req_o(vrf_rd_req_o), .vrf_rd_addr_o(vrf_rd_addr_o),
    .vrf_rd_gnt_i(vrf_rd_gnt_i), .vrf_rd_data_i(vrf_rd_data_i),
    .op_valid_o(op_valid_o), .op_ready_i(op_ready_i), .alu_op_o(alu_op_o),
    .feed_done_o(feed_done_o), .feed_done_id_o(feed_done_id_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] vlb;
    logic [1:0]  use_vs;
    logic [4:0]  base0;
    logic [4:0]  base1;
    logic [3:0]  id;
    bit          tog;
    bit          stall;
    int          w0;
    int          w1;
  } vec_t;

  vec_t vecs[7];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit auto_drv = 1'b1;
  bit tog_gnt  = 1'b0;
  bit stall0   = 1'b0;
  int stall_start = 0;

  int         rd_cnt[2], push_cnt[2], first_push[2], last_push[2];
  int         done_cnt, done_cyc, acc_cyc, viol_cnt, max_out;
  logic [3:0] done_id;
  logic [4:0]  addr_log[2][16];
  logic [63:0] data_log[2][16];

  function automatic logic [63:0] pat(input int p, input logic [4:0] a);
    return 64'hA5A5_0000_0000_0000 | (64'(p) << 8) | 64'(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    for (int p = 0; p < 2; p++) begin
      rd_cnt[p] = 0; push_cnt[p] = 0; first_push[p] = -1; last_push[p] = -1;
    end
    done_cnt = 0; done_cyc = -1; acc_cyc = -1; viol_cnt = 0; max_out = 0; done_id = 'x;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // VRF model: data for a granted address appears exactly one cycle later.
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++)
      vrf_rd_data_i[p] <= (vrf_rd_req_o[p] && vrf_rd_gnt_i[p]) ? pat(p, vrf_rd_addr_o[p])
                                                                : 64'hDEAD_BEEF_DEAD_BEEF;
  end

  always @(posedge clk) begin
    #1;
    if (auto_drv) begin
      vrf_rd_gnt_i  = tog_gnt ? {2{cyc[0]}} : 2'b11;
      op_ready_i[0] = !(stall0 && cyc >= stall_start && cyc < stall_start + 5);
      op_ready_i[1] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (req_valid_i && req_ready_o) acc_cyc = cyc;
    for (int p = 0; p < 2; p++) begin
      if (vrf_rd_req_o[p] && vrf_rd_gnt_i[p]) begin
        if (rd_cnt[p] < 16) addr_log[p][rd_cnt[p]] = vrf_rd_addr_o[p];
        rd_cnt[p]++;
      end
      if (op_valid_o[p]) begin
        if (!op_ready_i[p]) viol_cnt++;
        if (push_cnt[p] < 16) data_log[p][push_cnt[p]] = alu_op_o[p];
        if (push_cnt[p] == 0) first_push[p] = cyc;
        last_push[p] = cyc;
        push_cnt[p]++;
      end
      if (rd_cnt[p] - push_cnt[p] > max_out) max_out = rd_cnt[p] - push_cnt[p];
    end
    if (feed_done_o) begin
      done_cnt++;
      done_cyc = cyc;
      done_id  = feed_done_id_o;
    end
  end

  task automatic run_job(input vec_t v, input string tag);
    int n;
    int w[2];
    logic [4:0] b[2];
    int lastmax;
    w[0] = v.w0; w[1] = v.w1; b[0] = v.base0; b[1] = v.base1;
    @(posedge clk); #1;
    clear_mon();
    tog_gnt = v.tog; stall0 = v.stall;
    req_vs_addr_i[0] = v.base0; req_vs_addr_i[1] = v.base1;
    req_use_vs_i = v.use_vs; req_vlB_i = v.vlb; req_insn_id_i = v.id;
    req_valid_i = 1'b1;
    n = 0;
    do begin wait_neg(); n++; end while (acc_cyc < 0 && n < 20);
    check({tag, " accept"}, 64'(acc_cyc >= 0), 64'd1);
    stall_start = acc_cyc + 3;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    wait_neg();
    check({tag, " ready_low_active"}, 64'(req_ready_o), 64'd0);
    n = 0;
    while (done_cnt == 0 && n < 300) begin wait_neg(); n++; end
    wait_neg();
    check({tag, " ready_after_done"}, 64'(req_ready_o), 64'd1);
    check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, " done_id"}, 64'(done_id), 64'(v.id));
    check({tag, " ready_viol"}, 64'(viol_cnt), 64'd0);
    check({tag, " outstanding_le_2"}, 64'(max_out <= 2), 64'd1);
    lastmax = acc_cyc;
    for (int p = 0; p < 2; p++) begin
      check($sformatf("%s reads%0d", tag, p), 64'(rd_cnt[p]), 64'(w[p]));
      check($sformatf("%s pushes%0d", tag, p), 64'(push_cnt[p]), 64'(w[p]));
      for (int k = 0; k < w[p] && k < 16 && k < rd_cnt[p] && k < push_cnt[p]; k++) begin
        logic [4:0] a;
        a = b[p] + 5'(k);
        check($sformatf("%s addr%0d_%0d", tag, p, k), 64'(addr_log[p][k]), 64'(a));
        check($sformatf("%s data%0d_%0d", tag, p, k), data_log[p][k], pat(p, a));
      end
      if (w[p] > 0 && last_push[p] > lastmax) lastmax = last_push[p];
      if (w[p] > 0 && !v.tog && !v.stall) begin
        check($sformatf("%s first_lat%0d", tag, p), 64'(first_push[p] - acc_cyc), 64'd2);
        check($sformatf("%s burst%0d", tag, p), 64'(last_push[p] - first_push[p]), 64'(w[p] - 1));
      end
    end
    check({tag, " done_lat"}, 64'(done_cyc - lastmax), 64'd1);
  endtask

  initial begin
    vecs[0] = '{16'd32, 2'b11, 5'd4,  5'd20, 4'd1, 1'b0, 1'b0, 4, 4};
    vecs[1] = '{16'd20, 2'b10, 5'd9,  5'd12, 4'd2, 1'b0, 1'b0, 0, 3};
    vecs[2] = '{16'd40, 2'b11, 5'd0,  5'd30, 4'd3, 1'b0, 1'b1, 5, 5};
    vecs[3] = '{16'd24, 2'b11, 5'd10, 5'd16, 4'd4, 1'b1, 1'b0, 3, 3};
    vecs[4] = '{16'd0,  2'b11, 5'd1,  5'd2,  4'd5, 1'b0, 1'b0, 0, 0};
    vecs[5] = '{16'd16, 2'b00, 5'd3,  5'd4,  4'd6, 1'b0, 1'b0, 0, 0};
    vecs[6] = '{16'd9,  2'b01, 5'd31, 5'd0,  4'd7, 1'b0, 1'b0, 2, 0};

    clear_mon();
    rst_i = 1'b1; req_valid_i = 1'b0; req_vs_addr_i = '0; req_use_vs_i = '0;
    req_vlB_i = '0; req_insn_id_i = '0; vrf_rd_gnt_i = 2'b11; op_ready_i = 2'b11;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    wait_neg();
    check("rst ready", 64'(req_ready_o), 64'd1);
    check("rst rd_req", 64'(vrf_rd_req_o), 64'd0);
    check("rst op_valid", 64'(op_valid_o), 64'd0);
    check("rst done", 64'(feed_done_o), 64'd0);

    for (int j = 0; j < 7; j++) run_job(vecs[j], $sformatf("job%0d", j));

    // Reset while a port-0 read is in flight; the returning word must vanish.
    begin
      int n;
      @(posedge clk); #1;
      clear_mon();
      auto_drv = 1'b0; vrf_rd_gnt_i = 2'b01; op_ready_i = 2'b00;
      req_vs_addr_i[0] = 5'd8; req_vs_addr_i[1] = 5'd0; req_use_vs_i = 2'b01;
      req_vlB_i = 16'd32; req_insn_id_i = 4'd9; req_valid_i = 1'b1;
      n = 0;
      do begin wait_neg(); n++; end while (acc_cyc < 0 && n < 20);
      @(posedge clk); #1 req_valid_i = 1'b0;
      n = 0;
      while (rd_cnt[0] == 0 && n < 20) begin wait_neg(); n++; end
      check("rstmid grant_seen", 64'(rd_cnt[0]), 64'd1);
      @(posedge clk); #1;
      rst_i = 1'b1; vrf_rd_gnt_i = 2'b00;
      @(posedge clk); #1;
      rst_i = 1'b0; op_ready_i = 2'b11;
      wait_neg();
      check("rstmid ready", 64'(req_ready_o), 64'd1);
      check("rstmid rd_req", 64'(vrf_rd_req_o), 64'd0);
      check("rstmid op_valid", 64'(op_valid_o), 64'd0);
      check("rstmid done", 64'(feed_done_o), 64'd0);
      repeat (5) wait_neg();
      check("rstmid no_push", 64'(push_cnt[0] + push_cnt[1]), 64'd0);
      check("rstmid no_done", 64'(done_cnt), 64'd0);
      auto_drv = 1'b1;
    end

    run_job(vecs[0], "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
